// File: rtl/wbq_pkg.sv
// Shared types and constants for the register-file writeback queue.
// The entry layout matches the 32x32 register file write port.
package wbq_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    localparam logic [REG_AW-1:0] X0 = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_bypass_match.sv
// Combinational priority match of one read address against the pending queue
// entries (oldest at head_ptr) and the registered write-port output stage.
module wbq_bypass_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = XLEN
) (
    input  logic [AW-1:0]                rs,
    input  wbq_entry_t                   entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head_ptr,
    input  logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         out_valid,
    input  logic [AW-1:0]                out_rd,
    input  logic [DW-1:0]                out_data,
    output logic                         hit,
    output logic [DW-1:0]                data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] idx;

    // Scan from the output stage through oldest to newest so the newest match wins.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (rs != X0) begin
            if (out_valid && (out_rd == rs)) begin
                hit  = 1'b1;
                data = out_data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_ptr + PW'(k);
                if ((CW'(k) < count) && (entries[idx].rd == rs)) begin
                    hit  = 1'b1;
                    data = entries[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file write port (A3/WD3/WE3).
// Define WBQ_BYPASS_EN to build the read-address forwarding comparators.
module regfile_wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = XLEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [AW-1:0]                in_rd,
    input  logic [DW-1:0]                in_data,
    input  logic                         drain_en,
    output logic [AW-1:0]                A3,
    output logic [DW-1:0]                WD3,
    output logic                         WE3,
    input  logic [AW-1:0]                rs1,
    input  logic [AW-1:0]                rs2,
    output logic                         byp1_hit,
    output logic                         byp2_hit,
    output logic [DW-1:0]                byp1_data,
    output logic [DW-1:0]                byp2_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wbq_entry_t      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   a3_q, a3_d;
    logic [DW-1:0]   wd3_q, wd3_d;
    logic            we3_q, we3_d;
    logic            push, pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;
    assign A3       = a3_q;
    assign WD3      = wd3_q;
    assign WE3      = we3_q;

    // Writes to x0 complete the handshake but never occupy a slot.
    assign push = in_valid && in_ready && (in_rd != X0);
    assign pop  = drain_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        we3_d    = pop;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            a3_d     = mem_q[rd_ptr_q].rd;
            wd3_d    = mem_q[rd_ptr_q].data;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a3_q     <= '0;
            wd3_q    <= '0;
            we3_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            we3_q    <= we3_d;
        end
    end

    // NOTE: entry storage is not reset; count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{rd: in_rd, data: in_data};
    end

`ifdef WBQ_BYPASS_EN
    wbq_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp1 (
        .rs        (rs1),
        .entries   (mem_q),
        .head_ptr  (rd_ptr_q),
        .count     (count_q),
        .out_valid (we3_q),
        .out_rd    (a3_q),
        .out_data  (wd3_q),
        .hit       (byp1_hit),
        .data      (byp1_data)
    );

    wbq_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp2 (
        .rs        (rs2),
        .entries   (mem_q),
        .head_ptr  (rd_ptr_q),
        .count     (count_q),
        .out_valid (we3_q),
        .out_rd    (a3_q),
        .out_data  (wd3_q),
        .hit       (byp2_hit),
        .data      (byp2_data)
    );
`else
    // Without forwarding, decode stalls while !empty || WE3.
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign byp1_hit  = 1'b0;
    assign byp2_hit  = 1'b0;
    assign byp1_data = '0;
    assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue (DEPTH=4).
// Bypass expectations follow WBQ_BYPASS_EN as compiled.
module tb_regfile_wb_queue;

`ifdef WBQ_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        drain_en;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [4:0]  rs1, rs2;
    logic        byp1_hit, byp2_hit;
    logic [31:0] byp1_data, byp2_data;
    logic [2:0]  count;
    logic        empty, full;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .drain_en  (drain_en),
        .A3        (A3),
        .WD3       (WD3),
        .WE3       (WE3),
        .rs1       (rs1),
        .rs2       (rs2),
        .byp1_hit  (byp1_hit),
        .byp2_hit  (byp2_hit),
        .byp1_data (byp1_data),
        .byp2_data (byp2_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  exp_rd [3];
    logic [31:0] exp_wd [3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
        drain_en = 1'b0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_we3", 32'(WE3), 0);
        check("rst_a3", 32'(A3), 0);
        check("rst_wd3", WD3, 0);
        check("rst_hit1", 32'(byp1_hit), 0);
        rst = 1'b0;

        // Single push then drain: WE3 one cycle after the push edge.
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hDEADBEEF; drain_en = 1'b1; rs1 = 5'd5;
        tick();
        in_valid = 1'b0;
        check("t1_count1", 32'(count), 1);
        check("t1_we3_lo", 32'(WE3), 0);
        check("t1_hit_q", 32'(byp1_hit), 32'(BYP_EN));
        tick();
        check("t1_we3", 32'(WE3), 1);
        check("t1_a3", 32'(A3), 5);
        check("t1_wd3", WD3, 32'hDEADBEEF);
        check("t1_count0", 32'(count), 0);
        check("t1_hit_out", 32'(byp1_hit), 32'(BYP_EN));
        if (BYP_EN) check("t1_data_out", byp1_data, 32'hDEADBEEF);
        tick();
        check("t1_we3_off", 32'(WE3), 0);
        check("t1_a3_hold", 32'(A3), 5);
        check("t1_hit_off", 32'(byp1_hit), 0);

        // Push to x0: accepted, discarded.
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'h1234; rs1 = 5'd0;
        check("t2_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("t2_count", 32'(count), 0);
        check("t2_empty", 32'(empty), 1);
        tick();
        check("t2_we3", 32'(WE3), 0);
        check("t2_hit_x0", 32'(byp1_hit), 0);

        // Fill with drain disabled, hold a fifth request, then drain in order.
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h100 + 32'(i);
            tick();
        end
        check("t3_full", 32'(full), 1);
        check("t3_ready", 32'(in_ready), 0);
        check("t3_count4", 32'(count), 4);
        in_rd = 5'd9; in_data = 32'h999;
        tick();
        check("t3_held_count", 32'(count), 4);
        check("t3_held_we3", 32'(WE3), 0);
        drain_en = 1'b1;
        tick();
        check("t3_pop1_we3", 32'(WE3), 1);
        check("t3_pop1_a3", 32'(A3), 1);
        check("t3_pop1_wd3", WD3, 32'h101);
        check("t3_pop1_count", 32'(count), 3);
        check("t3_pop1_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("t3_pp_a3", 32'(A3), 2);
        check("t3_pp_wd3", WD3, 32'h102);
        check("t3_pp_count", 32'(count), 3);
        exp_rd[0] = 5'd3; exp_wd[0] = 32'h103;
        exp_rd[1] = 5'd4; exp_wd[1] = 32'h104;
        exp_rd[2] = 5'd9; exp_wd[2] = 32'h999;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t3_drain%0d_we3", i), 32'(WE3), 1);
            check($sformatf("t3_drain%0d_a3", i), 32'(A3), 32'(exp_rd[i]));
            check($sformatf("t3_drain%0d_wd3", i), WD3, exp_wd[i]);
            check($sformatf("t3_drain%0d_count", i), 32'(count), 32'(2 - i));
        end
        tick();
        check("t3_idle_we3", 32'(WE3), 0);

        // Duplicate rd: newest queued value wins over older entry and output stage.
        drain_en = 1'b0;
        in_valid = 1'b1; in_rd = 5'd7; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd8;
        #1;
        check("t4_count2", 32'(count), 2);
        check("t4_hit1", 32'(byp1_hit), 32'(BYP_EN));
        check("t4_data1", byp1_data, BYP_EN ? 32'hB : 32'h0);
        check("t4_hit2_miss", 32'(byp2_hit), 0);
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        check("t4_pop_wd3", WD3, 32'hA);
        check("t4_pop_count", 32'(count), 1);
        check("t4_after_data1", byp1_data, BYP_EN ? 32'hB : 32'h0);
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        check("t4_pop2_wd3", WD3, 32'hB);
        check("t4_out_hit", 32'(byp1_hit), 32'(BYP_EN));
        check("t4_out_data", byp1_data, BYP_EN ? 32'hB : 32'h0);
        tick();
        check("t4_end_hit", 32'(byp1_hit), 0);

        // Async reset with 3 entries queued and WE3 high.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_rd = 5'(10 + i); in_data = 32'hC0 + 32'(i);
            tick();
        end
        in_valid = 1'b0; drain_en = 1'b1; rs1 = 5'd12;
        tick();
        check("t6_pre_we3", 32'(WE3), 1);
        check("t6_pre_a3", 32'(A3), 10);
        check("t6_pre_count", 32'(count), 3);
        check("t6_pre_hit", 32'(byp1_hit), 32'(BYP_EN));
        #2 rst = 1'b1;
        #1;
        check("t6_rst_we3", 32'(WE3), 0);
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_empty", 32'(empty), 1);
        check("t6_rst_hit", 32'(byp1_hit), 0);
        check("t6_rst_a3", 32'(A3), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_post%0d_we3", i), 32'(WE3), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
